mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 8-bit three-input operand mux between three requesters (sources a, b, c).
- Drives the mux select `ctrl` and captures the selected word into a registered output with a valid/ready handshake toward the ALU.
- Bounds each grant to a burst of at most MAX_BURST beats so that no single source can starve the others.

---
 rtl/mux_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin arbiter in front of the shared three-input operand mux. It owns
//   the mux select, captures the selected word into a registered output with a
//   valid/ready handshake toward the ALU, and caps every grant at MAX_BURST
//   captured beats so that no source can starve the others.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req[2:0]   per-source request (bit0=a, bit1=b, bit2=c)
//   a, b, c    source data words (signed, passed through unmodified)
//   ready      downstream accepts s this cycle
//   ctrl[1:0]  registered mux select: 00=a, 01=b, 10=c, 11=idle
//   gnt[2:0]   registered one-hot grant, 000 when idle
//   take[2:0]  one-cycle pulse on the source whose word was captured into s
//   s          registered selected data
//   out_valid  s holds an unconsumed word
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             ready,
  output logic [1:0]       ctrl,
  output logic [2:0]       gnt,
  output logic [2:0]       take,
  output logic [WIDTH-1:0] s,
  output logic             out_valid
);

  // Beat counter wide enough for the largest legal burst (15).
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] CTRL_IDLE = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [2:0]       take_q, take_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [1:0]       last_q, last_d;

  logic             owner_req;
  logic             capture;
  logic [CNT_W-1:0] beat_nxt;
  logic [WIDTH-1:0] sel_data;
  logic [1:0]       winner;

  // Rotating priority: last+1 first, the last-granted source goes last.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    case (last)
      2'd0:    pick = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd1:    pick = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: pick = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
    return pick;
  endfunction

  // Operand mux; the idle code never selects a source.
  always_comb begin
    sel_data = s_q;
    case (ctrl_q)
      2'b00:   sel_data = a;
      2'b01:   sel_data = b;
      2'b10:   sel_data = c;
      default: sel_data = s_q;
    endcase
  end

  // The grant vector is one-hot on the owner, so masking req with it gives
  // the owner's request without indexing by the pointer.
  always_comb begin
    owner_req = |(req & gnt_q);
    capture   = (state_q == BUSY) && owner_req && (!out_valid_q || ready) &&
                (beat_q < CNT_W'(MAX_BURST));
    beat_nxt  = beat_q + CNT_W'(capture);
    winner    = rr_pick(req, last_q);
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    gnt_d       = gnt_q;
    take_d      = 3'b000;
    s_d         = s_q;
    out_valid_d = out_valid_q;
    beat_d      = beat_q;
    last_d      = last_q;

    // A pending word drains whenever the ALU accepts it and nothing replaces it.
    if (capture) begin
      s_d         = sel_data;
      out_valid_d = 1'b1;
      take_d      = gnt_q;
      beat_d      = beat_nxt;
    end else if (ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        ctrl_d = CTRL_IDLE;
        gnt_d  = 3'b000;
        if (req != 3'b000) begin
          state_d = BUSY;
          ctrl_d  = winner;
          gnt_d   = 3'(3'b001 << winner);
          beat_d  = '0;
          last_d  = winner;
        end
      end
      BUSY: begin
        // Release on a dropped request or once the burst budget is spent.
        if (!owner_req || (beat_nxt == CNT_W'(MAX_BURST))) begin
          state_d = IDLE;
          ctrl_d  = CTRL_IDLE;
          gnt_d   = 3'b000;
        end
      end
      default: begin
        state_d = IDLE;
        ctrl_d  = CTRL_IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctrl_q      <= CTRL_IDLE;
      gnt_q       <= 3'b000;
      take_q      <= 3'b000;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      beat_q      <= '0;
      last_q      <= 2'd2;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      gnt_q       <= gnt_d;
      take_q      <= take_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign gnt       = gnt_q;
  assign take      = take_q;
  assign s         = s_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed scenarios plus randomized traffic for mux_rr_arbiter, checked every
//   cycle against a transaction-level reference model (owner index, burst
//   count, single pending output word).
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk;
  logic             rst_n;
  logic [2:0]       req;
  logic [WIDTH-1:0] a, b, c;
  logic             ready;
  logic [1:0]       ctrl;
  logic [2:0]       gnt;
  logic [2:0]       take;
  logic [WIDTH-1:0] s;
  logic             out_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: owner is -1 while idle.
  int               m_owner;
  int               m_last;
  int               m_beats;
  logic [WIDTH-1:0] m_s;
  logic             m_valid;
  logic [2:0]       m_take;

  mux_rr_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a        (a),
    .b        (b),
    .c        (c),
    .ready    (ready),
    .ctrl     (ctrl),
    .gnt      (gnt),
    .take     (take),
    .s        (s),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic req_bit(input logic [2:0] r, input int i);
    return ((r >> i) & 3'b001) != 3'b000;
  endfunction

  // One clock of the reference model, applied with the inputs the DUT sees.
  task automatic model_step(input logic rst_i, input logic [2:0] r,
                            input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                            input logic [WIDTH-1:0] vc, input logic rdy);
    logic [WIDTH-1:0] sel;
    logic             cap;
    int               idx;
    m_take = 3'b000;
    if (!rst_i) begin
      m_owner = -1;
      m_last  = 2;
      m_beats = 0;
      m_s     = '0;
      m_valid = 1'b0;
    end else if (m_owner < 0) begin
      if (rdy && m_valid) m_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last + k) % 3;
        if (m_owner < 0 && req_bit(r, idx)) m_owner = idx;
      end
      if (m_owner >= 0) begin
        m_last  = m_owner;
        m_beats = 0;
      end
    end else begin
      sel = (m_owner == 0) ? va : ((m_owner == 1) ? vb : vc);
      cap = req_bit(r, m_owner) && (!m_valid || rdy) && (m_beats < MAX_BURST);
      if (cap) begin
        m_s     = sel;
        m_valid = 1'b1;
        m_take  = 3'(1 << m_owner);
        m_beats++;
      end else if (rdy && m_valid) begin
        m_valid = 1'b0;
      end
      if (!req_bit(r, m_owner) || m_beats == MAX_BURST) m_owner = -1;
    end
  endtask

  // Apply inputs, advance one clock edge, compare every output on the far edge.
  task automatic cycle(input logic rst_i, input logic [2:0] r,
                       input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic [WIDTH-1:0] vc, input logic rdy);
    logic [1:0] e_ctrl;
    logic [2:0] e_gnt;
    rst_n = rst_i;
    req   = r;
    a     = va;
    b     = vb;
    c     = vc;
    ready = rdy;
    model_step(rst_i, r, va, vb, vc, rdy);
    @(negedge clk);
    e_ctrl = (m_owner < 0) ? 2'b11 : 2'(m_owner);
    e_gnt  = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    chk("ctrl",      32'(ctrl),      32'(e_ctrl));
    chk("gnt",       32'(gnt),       32'(e_gnt));
    chk("take",      32'(take),      32'(m_take));
    chk("s",         32'(s),         32'(m_s));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
  endtask

  task automatic do_reset();
    cycle(1'b0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
    cycle(1'b0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
  endtask

  initial begin
    int               ntake;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] caps[$];
    logic [WIDTH-1:0] exp_s;
    logic [2:0]       rr;
    logic             rdy;
    logic             rst_i;

    rst_n = 1'b0;
    req   = 3'b000;
    a     = '0;
    b     = '0;
    c     = '0;
    ready = 1'b0;

    // Reset, then first grant and capture from a.
    do_reset();
    chk("rst_ctrl", 32'(ctrl), 32'h3);
    chk("rst_gnt",  32'(gnt),  32'h0);
    chk("rst_s",    32'(s),    32'h0);
    chk("rst_ov",   32'(out_valid), 32'h0);
    cycle(1'b1, 3'b001, 8'd5, 8'd0, 8'd0, 1'b1);
    chk("t1_gnt",  32'(gnt),  32'h1);
    chk("t1_ctrl", 32'(ctrl), 32'h0);
    cycle(1'b1, 3'b001, 8'd5, 8'd0, 8'd0, 1'b1);
    chk("t1_s",    32'(s),    32'h5);
    chk("t1_ov",   32'(out_valid), 32'h1);
    chk("t1_take", 32'(take), 32'h1);

    // Burst limit with a single requester.
    do_reset();
    v = 8'd1;
    ntake = 0;
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b1, 3'b001, v, 8'd0, 8'd0, 1'b1);
      if (k <= 6 && take != 3'b000) ntake++;
      if (take != 3'b000) v = v + 8'd1;
      if (k == 5) chk("t2_idle_ctrl", 32'(ctrl), 32'h3);
      if (k == 6) chk("t2_regnt", 32'(gnt), 32'h1);
      if (k == 7) chk("t2_s5", 32'(s), 32'h5);
    end
    chk("t2_ntake", 32'(ntake), 32'd4);

    // Round robin across three constant requesters.
    do_reset();
    caps.delete();
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b1, 3'b111, 8'd5, 8'd10, 8'd15, 1'b1);
      if (take != 3'b000) caps.push_back(s);
    end
    chk("t3_ncap", 32'(caps.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_s = (i < 4) ? 8'd5 : (i < 8) ? 8'd10 : (i < 12) ? 8'd15 : 8'd5;
      if (i < caps.size()) chk("t3_seq", 32'(caps[i]), 32'(exp_s));
    end

    // Backpressure holds s and the beat count.
    do_reset();
    cycle(1'b1, 3'b010, 8'd0, 8'hFD, 8'd0, 1'b1);
    cycle(1'b1, 3'b010, 8'd0, 8'hFD, 8'd0, 1'b1);
    chk("t4_take1", 32'(take), 32'h2);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 3'b010, 8'd0, 8'h44, 8'd0, 1'b0);
      chk("t4_hold_s",    32'(s),    32'hFD);
      chk("t4_hold_ov",   32'(out_valid), 32'h1);
      chk("t4_hold_take", 32'(take), 32'h0);
    end
    cycle(1'b1, 3'b010, 8'd0, 8'hFD, 8'd0, 1'b1);
    chk("t4_take2", 32'(take), 32'h2);
    cycle(1'b1, 3'b010, 8'd0, 8'hFD, 8'd0, 1'b1);
    chk("t4_beat3_ctrl", 32'(ctrl), 32'h1);
    cycle(1'b1, 3'b010, 8'd0, 8'hFD, 8'd0, 1'b1);
    chk("t4_beat4_ctrl", 32'(ctrl), 32'h3);

    // Owner drops its request mid-burst.
    do_reset();
    cycle(1'b1, 3'b100, 8'd0, 8'd0, 8'd15, 1'b1);
    cycle(1'b1, 3'b100, 8'd0, 8'd0, 8'd15, 1'b1);
    cycle(1'b1, 3'b100, 8'd0, 8'd0, 8'd15, 1'b1);
    cycle(1'b1, 3'b000, 8'd0, 8'd0, 8'd15, 1'b0);
    chk("t5_ctrl", 32'(ctrl), 32'h3);
    chk("t5_take", 32'(take), 32'h0);
    chk("t5_s",    32'(s),    32'd15);
    cycle(1'b1, 3'b000, 8'd0, 8'd0, 8'd0, 1'b0);
    chk("t5_pend", 32'(out_valid), 32'h1);
    cycle(1'b1, 3'b000, 8'd0, 8'd0, 8'd0, 1'b1);
    chk("t5_drain", 32'(out_valid), 32'h0);

    // Reset in the middle of a burst.
    do_reset();
    cycle(1'b1, 3'b010, 8'd0, 8'd7, 8'd0, 1'b1);
    cycle(1'b1, 3'b010, 8'd0, 8'd7, 8'd0, 1'b1);
    chk("t6_ov", 32'(out_valid), 32'h1);
    cycle(1'b0, 3'b111, 8'd1, 8'd7, 8'd3, 1'b1);
    chk("t6_ctrl", 32'(ctrl), 32'h3);
    chk("t6_gnt",  32'(gnt),  32'h0);
    chk("t6_s",    32'(s),    32'h0);
    chk("t6_ov0",  32'(out_valid), 32'h0);
    cycle(1'b1, 3'b111, 8'd1, 8'd7, 8'd3, 1'b1);
    chk("t6_gnt_a", 32'(gnt), 32'h1);

    // Randomized traffic with sticky requests and occasional resets.
    rr = 3'b000;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rr = 3'($urandom_range(0, 7));
      rdy   = ($urandom_range(0, 3) != 0);
      rst_i = ($urandom_range(0, 199) != 0);
      cycle(rst_i, rr, 8'($urandom), 8'($urandom), 8'($urandom), rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
